// File: rtl/tcm_dport_pkg.sv
// Shared types for the TCM data-port master: tag width, request FSM states,
// and the layout of one response-buffer slot.
package tcm_dport_pkg;

    localparam int unsigned TAG_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        is_wr;
        logic        err;
        logic [31:0] data;
    } rob_slot_t;

endpackage

// File: rtl/tcm_dport_master_if.sv
// Data-port memory bus between the master and the TCM/memory responder.
interface tcm_dport_master_if;
    import tcm_dport_pkg::*;

    logic [31:0]      mem_d_addr_o;
    logic [31:0]      mem_d_data_wr_o;
    logic             mem_d_rd_o;
    logic [3:0]       mem_d_wr_o;
    logic [TAG_W-1:0] mem_d_req_tag_o;
    logic             mem_d_cacheable_o;
    logic             mem_d_flush_o;
    logic             mem_d_invalidate_o;
    logic             mem_d_writeback_o;
    logic             mem_d_accept_i;
    logic             mem_d_ack_i;
    logic             mem_d_error_i;
    logic [31:0]      mem_d_data_rd_i;
    logic [TAG_W-1:0] mem_d_resp_tag_i;

    modport master (
        output mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
        output mem_d_req_tag_o, mem_d_cacheable_o, mem_d_flush_o,
        output mem_d_invalidate_o, mem_d_writeback_o,
        input  mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        input  mem_d_data_rd_i, mem_d_resp_tag_i
    );

    modport slave (
        input  mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
        input  mem_d_req_tag_o, mem_d_cacheable_o, mem_d_flush_o,
        input  mem_d_invalidate_o, mem_d_writeback_o,
        output mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        output mem_d_data_rd_i, mem_d_resp_tag_i
    );

endinterface

// File: rtl/tcm_dport_rob.sv
// In-order response buffer: slots allocated at the tail in command order,
// completed out of order by tag index, drained from the head.
module tcm_dport_rob
    import tcm_dport_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_i,
    input  logic             alloc_done_i,
    input  logic             alloc_wr_i,
    input  logic             alloc_err_i,
    input  logic             ack_i,
    input  logic [IW-1:0]    ack_idx_i,
    input  logic             ack_err_i,
    input  logic [31:0]      ack_data_i,
    input  logic             pop_i,
    output logic [IW-1:0]    tail_o,
    output logic [IW:0]      count_o,
    output logic [DEPTH-1:0] pending_o,
    output logic             head_valid_o,
    output logic             head_err_o,
    output logic [31:0]      head_data_o
);

    rob_slot_t     slots_q [DEPTH];
    rob_slot_t     slots_d [DEPTH];
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [IW:0]   count_q, count_d;

    // Slot updates: allocate at tail, complete by tag, release at head
    always_comb begin
        slots_d = slots_q;
        if (alloc_i) begin
            slots_d[tail_q] = '{valid: 1'b1, done: alloc_done_i, is_wr: alloc_wr_i,
                                err: alloc_err_i, data: 32'h0};
        end
        if (ack_i) begin
            slots_d[ack_idx_i].done = 1'b1;
            slots_d[ack_idx_i].err  = ack_err_i;
            slots_d[ack_idx_i].data = slots_q[ack_idx_i].is_wr ? 32'h0 : ack_data_i;
        end
        if (pop_i) begin
            slots_d[head_q].valid = 1'b0;
            slots_d[head_q].done  = 1'b0;
        end
        tail_d  = tail_q + IW'(alloc_i);
        head_d  = head_q + IW'(pop_i);
        count_d = count_q + (IW+1)'(alloc_i) - (IW+1)'(pop_i);
    end

    // Slot storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slots issued to memory and still awaiting their ack
    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pending_o[i] = slots_q[i].valid & ~slots_q[i].done;
        end
    end

    assign tail_o       = tail_q;
    assign count_o      = count_q;
    assign head_valid_o = slots_q[head_q].valid & slots_q[head_q].done;
    assign head_err_o   = slots_q[head_q].err;
    assign head_data_o  = slots_q[head_q].data;

endmodule

// File: rtl/tcm_dport_master.sv
// TCM data-port master: one-entry request register toward memory, tagged
// out-of-order acks reordered so responses leave in command order.
module tcm_dport_master
    import tcm_dport_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [3:0]                cmd_wr_i,
    input  logic [31:0]               cmd_addr_i,
    input  logic [31:0]               cmd_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_data_o,
    output logic                      rsp_error_o,
    output logic                      unexpected_ack_o,
    tcm_dport_master_if.master        mem_d
);

    localparam int unsigned IW = $clog2(MAX_OUTSTANDING);

    state_t                 state_q, state_d;
    logic                   rd_q, rd_d;
    logic [3:0]             wr_q, wr_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   unexp_q, unexp_d;

    logic [IW-1:0]          issue_idx;
    logic [IW:0]            in_flight;
    logic [MAX_OUTSTANDING-1:0] pending;
    logic                   head_valid, head_err;
    logic [31:0]            head_data;

    logic mem_issue, cmd_fire, misaligned, ack_hit, rsp_pop;
    logic [IW-1:0] ack_idx;

    assign mem_issue   = (state_q == REQ) & mem_d.mem_d_accept_i;
    assign cmd_ready_o = rst_i & ((state_q == IDLE) | mem_d.mem_d_accept_i)
                       & (in_flight < (IW+1)'(MAX_OUTSTANDING));
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign misaligned  = cmd_addr_i[1:0] != 2'b00;

    // An ack is honoured only for an issued, not-yet-completed slot; the
    // request still held in the register has not been accepted by memory.
    assign ack_idx = mem_d.mem_d_resp_tag_i[IW-1:0];
    assign ack_hit = mem_d.mem_d_ack_i
                   & (mem_d.mem_d_resp_tag_i[TAG_W-1:IW] == '0)
                   & pending[ack_idx]
                   & ~((state_q == REQ) & (tag_q == mem_d.mem_d_resp_tag_i));

    assign rsp_pop = head_valid & rsp_ready_i;

    // Request register next state: clear on memory accept, load on new aligned command
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (mem_issue) begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 4'b0;
        end
        if (cmd_fire && !misaligned) begin
            state_d = REQ;
            rd_d    = (cmd_wr_i == 4'b0);
            wr_d    = cmd_wr_i;
            addr_d  = cmd_addr_i;
            data_d  = cmd_data_i;
            tag_d   = TAG_W'(issue_idx);
        end
        unexp_d = unexp_q | (mem_d.mem_d_ack_i & ~ack_hit);
    end

    // Request register and sticky unexpected-ack flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            unexp_q <= unexp_d;
        end
    end

    tcm_dport_rob #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_rob (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_i      (cmd_fire),
        .alloc_done_i (misaligned),
        .alloc_wr_i   (cmd_wr_i != 4'b0),
        .alloc_err_i  (misaligned),
        .ack_i        (ack_hit),
        .ack_idx_i    (ack_idx),
        .ack_err_i    (mem_d.mem_d_error_i),
        .ack_data_i   (mem_d.mem_d_data_rd_i),
        .pop_i        (rsp_pop),
        .tail_o       (issue_idx),
        .count_o      (in_flight),
        .pending_o    (pending),
        .head_valid_o (head_valid),
        .head_err_o   (head_err),
        .head_data_o  (head_data)
    );

    assign rsp_valid_o      = head_valid;
    assign rsp_data_o       = head_valid ? head_data : 32'h0;
    assign rsp_error_o      = head_valid & head_err;
    assign unexpected_ack_o = unexp_q;

    assign mem_d.mem_d_addr_o       = addr_q;
    assign mem_d.mem_d_data_wr_o    = data_q;
    assign mem_d.mem_d_rd_o         = rd_q;
    assign mem_d.mem_d_wr_o         = wr_q;
    assign mem_d.mem_d_req_tag_o    = tag_q;
    assign mem_d.mem_d_cacheable_o  = 1'b1;
    assign mem_d.mem_d_flush_o      = 1'b0;
    assign mem_d.mem_d_invalidate_o = 1'b0;
    assign mem_d.mem_d_writeback_o  = 1'b0;

endmodule

// File: tb/tb_tcm_dport_master.sv
// Directed bench for tcm_dport_master with a hand-driven memory responder.
module tb_tcm_dport_master;
    import tcm_dport_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_wr;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_ready, rsp_error, unexpected;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcm_dport_master_if mem_if ();

    tcm_dport_master #(
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_wr_i         (cmd_wr),
        .cmd_addr_i       (cmd_addr),
        .cmd_data_i       (cmd_data),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .rsp_error_o      (rsp_error),
        .unexpected_ack_o (unexpected),
        .mem_d            (mem_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
    endtask

    task automatic ack(input logic [10:0] tag, input logic [31:0] data);
        mem_if.mem_d_ack_i      = 1'b1;
        mem_if.mem_d_resp_tag_i = tag;
        mem_if.mem_d_data_rd_i  = data;
        mem_if.mem_d_error_i    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ready"},  cmd_ready, 0);
        chk({pfx, "_rvalid"}, rsp_valid, 0);
        chk({pfx, "_rdata"},  rsp_data, 0);
        chk({pfx, "_rerr"},   rsp_error, 0);
        chk({pfx, "_unexp"},  unexpected, 0);
        chk({pfx, "_rd"},     mem_if.mem_d_rd_o, 0);
        chk({pfx, "_wr"},     mem_if.mem_d_wr_o, 0);
        chk({pfx, "_tag"},    mem_if.mem_d_req_tag_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_wr = '0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        mem_if.mem_d_accept_i   = 1'b1;
        mem_if.mem_d_ack_i      = 1'b0;
        mem_if.mem_d_error_i    = 1'b0;
        mem_if.mem_d_data_rd_i  = '0;
        mem_if.mem_d_resp_tag_i = '0;

        // Reset state, with a command offered during reset
        #3;
        send(4'b0, 32'h0000_0100, 32'h0);
        #1;
        check_reset_outputs("rst");
        chk("tie_cacheable", mem_if.mem_d_cacheable_o, 1);
        chk("tie_flush", mem_if.mem_d_flush_o, 0);
        chk("tie_inval", mem_if.mem_d_invalidate_o, 0);
        chk("tie_wb", mem_if.mem_d_writeback_o, 0);
        cmd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Read 0x100, zero-wait responder, 3-cycle latency
        send(4'b0, 32'h0000_0100, 32'h0);
        #1 chk("rd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("rd_memrd", mem_if.mem_d_rd_o, 1);
        chk("rd_addr", mem_if.mem_d_addr_o, 32'h0000_0100);
        chk("rd_tag", mem_if.mem_d_req_tag_o, 0);
        chk("rd_rvalid_c1", rsp_valid, 0);
        step();
        chk("rd_memrd_drop", mem_if.mem_d_rd_o, 0);
        chk("rd_rvalid_c2", rsp_valid, 0);
        ack(11'd0, 32'hDEAD_BEEF);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("rd_rvalid_c3", rsp_valid, 1);
        chk("rd_rdata", rsp_data, 32'hDEAD_BEEF);
        chk("rd_rerr", rsp_error, 0);
        step();
        chk("rd_rvalid_done", rsp_valid, 0);

        // Write 0x104 strobe 0011
        send(4'b0011, 32'h0000_0104, 32'h1234_5678);
        step();
        cmd_valid = 1'b0;
        chk("wr_strobe", mem_if.mem_d_wr_o, 4'b0011);
        chk("wr_rd", mem_if.mem_d_rd_o, 0);
        chk("wr_addr", mem_if.mem_d_addr_o, 32'h0000_0104);
        chk("wr_data", mem_if.mem_d_data_wr_o, 32'h1234_5678);
        chk("wr_tag", mem_if.mem_d_req_tag_o, 1);
        step();
        chk("wr_strobe_drop", mem_if.mem_d_wr_o, 0);
        ack(11'd1, 32'hFFFF_FFFF);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("wr_rvalid", rsp_valid, 1);
        chk("wr_rdata", rsp_data, 0);
        chk("wr_rerr", rsp_error, 0);
        step();

        // Memory stalls accept for 5 cycles
        mem_if.mem_d_accept_i = 1'b0;
        send(4'b0, 32'h0000_0200, 32'h0);
        step();
        cmd_addr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rd", mem_if.mem_d_rd_o, 1);
            chk("stall_addr", mem_if.mem_d_addr_o, 32'h0000_0200);
            chk("stall_tag", mem_if.mem_d_req_tag_o, 2);
            chk("stall_ready", cmd_ready, 0);
            step();
        end
        mem_if.mem_d_accept_i = 1'b1;
        #1 chk("stall_release_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("stall_next_addr", mem_if.mem_d_addr_o, 32'h0000_0300);
        chk("stall_next_tag", mem_if.mem_d_req_tag_o, 3);
        chk("stall_next_rd", mem_if.mem_d_rd_o, 1);
        step();
        chk("stall_rd_drop", mem_if.mem_d_rd_o, 0);
        ack(11'd2, 32'h0000_000A);
        step();
        ack(11'd3, 32'h0000_000B);
        chk("stall_rsp0", rsp_data, 32'h0000_000A);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("stall_rsp1", rsp_data, 32'h0000_000B);
        step();
        chk("stall_rvalid_done", rsp_valid, 0);

        // Four reads, acks 2,0,3,1, in-order delivery, fifth stalls
        rsp_ready = 1'b0;
        send(4'b0, 32'h0000_0400, 32'h0);
        #1 chk("ooo_ready0", cmd_ready, 1);
        step();
        cmd_addr = 32'h0000_0404;
        #1 chk("ooo_ready1", cmd_ready, 1);
        step();
        cmd_addr = 32'h0000_0408;
        step();
        cmd_addr = 32'h0000_040C;
        step();
        cmd_addr = 32'h0000_0410;
        #1 chk("ooo_full_ready", cmd_ready, 0);
        ack(11'd2, 32'h2222_2222);
        step();
        ack(11'd0, 32'h1111_0000);
        chk("ooo_full_ready2", cmd_ready, 0);
        step();
        ack(11'd3, 32'h3333_3333);
        chk("ooo_rvalid_head", rsp_valid, 1);
        chk("ooo_rsp0", rsp_data, 32'h1111_0000);
        step();
        ack(11'd1, 32'h1111_1111);
        chk("ooo_rsp0_hold", rsp_data, 32'h1111_0000);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("ooo_rsp0_hold2", rsp_data, 32'h1111_0000);
        chk("ooo_full_ready3", cmd_ready, 0);
        rsp_ready = 1'b1;
        step();
        chk("ooo_rsp1", rsp_data, 32'h1111_1111);
        chk("ooo_fifth_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("ooo_rsp2", rsp_data, 32'h2222_2222);
        chk("ooo_fifth_rd", mem_if.mem_d_rd_o, 1);
        chk("ooo_fifth_tag", mem_if.mem_d_req_tag_o, 0);
        chk("ooo_fifth_addr", mem_if.mem_d_addr_o, 32'h0000_0410);
        step();
        chk("ooo_rsp3", rsp_data, 32'h3333_3333);
        ack(11'd0, 32'h4444_4444);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("ooo_rsp4", rsp_data, 32'h4444_4444);
        step();
        chk("ooo_rvalid_done", rsp_valid, 0);

        // Misaligned read, then a stray ack
        send(4'b0, 32'h0000_0102, 32'h0);
        #1 chk("mis_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("mis_no_rd", mem_if.mem_d_rd_o, 0);
        chk("mis_rvalid", rsp_valid, 1);
        chk("mis_rerr", rsp_error, 1);
        chk("mis_rdata", rsp_data, 0);
        step();
        chk("mis_rvalid_done", rsp_valid, 0);
        chk("unexp_before", unexpected, 0);
        ack(11'd7, 32'h7777_7777);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("unexp_set", unexpected, 1);
        step();
        step();
        chk("unexp_sticky", unexpected, 1);

        // Reset with three in flight, then a normal read
        rsp_ready = 1'b0;
        send(4'b0, 32'h0000_0600, 32'h0);
        step();
        cmd_addr = 32'h0000_0604;
        step();
        cmd_addr = 32'h0000_0608;
        ack(11'd2, 32'h6666_6666);
        step();
        cmd_valid = 1'b0;
        mem_if.mem_d_ack_i = 1'b0;
        chk("mid_rvalid", rsp_valid, 1);
        chk("mid_rd", mem_if.mem_d_rd_o, 1);
        chk("mid_tag", mem_if.mem_d_req_tag_o, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        step();
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        send(4'b0, 32'h0000_0500, 32'h0);
        #1 chk("post_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("post_rd", mem_if.mem_d_rd_o, 1);
        chk("post_addr", mem_if.mem_d_addr_o, 32'h0000_0500);
        chk("post_tag", mem_if.mem_d_req_tag_o, 0);
        step();
        ack(11'd0, 32'h55AA_55AA);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("post_rvalid", rsp_valid, 1);
        chk("post_rdata", rsp_data, 32'h55AA_55AA);
        step();
        chk("post_rvalid_done", rsp_valid, 0);
        chk("post_unexp_clear", unexpected, 0);
        ack(11'd3, 32'h0);
        step();
        mem_if.mem_d_ack_i = 1'b0;
        chk("post_stale_ack", unexpected, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcm_dport_master.md
TCM_DPORT_MASTER -- requirements
Module: tcm_dport_master

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, power of two 2..8: maximum in-flight data-port transactions.
REQ-002 clk_i  in  1  single clock; all logic rising-edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid_i  in  1  command present.
REQ-005 cmd_ready_o  out  1  command accepted when valid&ready.
REQ-006 cmd_wr_i  in  4  byte write strobes; 4'b0 = read.
REQ-007 cmd_addr_i  in  32  byte address.
REQ-008 cmd_data_i  in  32  write data.
REQ-009 rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake.
REQ-010 rsp_data_o  out  32  read data (0 for writes).
REQ-011 rsp_error_o  out  1  memory error or misaligned command.
REQ-012 mem_d_addr_o, mem_d_data_wr_o  out  32  request address and write data.
REQ-013 mem_d_rd_o  out  1; mem_d_wr_o  out  4; mem_d_req_tag_o  out  11.
REQ-014 mem_d_cacheable_o, mem_d_flush_o, mem_d_invalidate_o, mem_d_writeback_o  out  1  tied: cacheable=1, others=0.
REQ-015 mem_d_accept_i, mem_d_ack_i, mem_d_error_i  in  1; mem_d_data_rd_i  in  32; mem_d_resp_tag_i  in  11.
REQ-016 unexpected_ack_o  out  1  sticky: ack received with tag not in flight.

Function
REQ-017 One-entry request register; states IDLE (empty) and REQ (holding); command accepted in IDLE, or in REQ in the same cycle mem_d_accept_i=1.
REQ-018 cmd_ready_o = (state==IDLE or mem_d_accept_i) and in_flight < MAX_OUTSTANDING; in_flight counts issued-or-held commands not yet delivered on rsp.
REQ-019 Command accepted at cycle N drives mem_d_rd_o/mem_d_wr_o from cycle N+1, held stable with addr/data/tag until mem_d_accept_i=1.
REQ-020 Tag = {zeros, issue_index}, issue_index a log2(MAX_OUTSTANDING)-bit wrapping counter incremented per accepted command.
REQ-021 Misaligned command (cmd_addr_i[1:0]!=0) issues no memory request; enters response buffer directly completed, rsp_error_o=1, rsp_data_o=0.
REQ-022 mem_d_ack_i stores data/error into response buffer slot tag[index]; ack for non-in-flight tag is dropped and sets unexpected_ack_o.
REQ-023 Responses delivered strictly in command order; rsp_valid_o registered, asserted cycle after head slot completes; held stable until rsp_ready_i.
REQ-024 With a zero-wait responder (accept=1, ack next cycle) read latency cmd accept -> rsp_valid_o is 3 cycles; sustained throughput 1 command/cycle with rsp_ready_i=1.
REQ-025 Simultaneous accept of new command and delivery of response: in_flight unchanged.
REQ-026 Buffer full (in_flight==MAX_OUTSTANDING): cmd_ready_o=0 until a response is delivered; no overflow possible.
REQ-027 Ack and rsp delivery in same cycle on same slot is impossible by construction (delivery only after completion registered).

Reset
REQ-028 On rst_i low: state IDLE, in_flight=0, issue/delivery pointers 0, all slots empty, cmd_ready_o=0 during reset, rsp_valid_o=0, mem_d_rd_o=0, mem_d_wr_o=0, mem_d_req_tag_o=0, rsp_data_o=0, rsp_error_o=0, unexpected_ack_o=0.
REQ-029 Reset mid-operation discards held and in-flight transactions; acks arriving after release are treated per REQ-022.

Structure
REQ-030 Package tcm_dport_pkg holds tag width (11), state enum {IDLE, REQ}, response-slot record type.
REQ-031 Sub-module tcm_dport_rob: MAX_OUTSTANDING-entry in-order response buffer with tag-indexed write, head read, valid/done flags.

Verification
REQ-032 Read 0x100 with zero-wait responder returning 0xDEADBEEF -> rsp_valid_o 3 cycles after accept, rsp_data_o=0xDEADBEEF, rsp_error_o=0.
REQ-033 Write 0x104 data 0x12345678 strobe 4'b0011 -> mem_d_wr_o=4'b0011 for one cycle, rsp_data_o=0, no error.
REQ-034 mem_d_accept_i low 5 cycles -> request fields stable all 5 cycles, single issue, cmd_ready_o=0 meanwhile.
REQ-035 Four reads tags 0..3, responder acks in order 2,0,3,1 with distinct data -> responses delivered tag order 0,1,2,3; fifth command stalls until first delivered.
REQ-036 Read at 0x102 -> no mem_d_rd_o pulse, rsp_error_o=1; ack with tag 7 when idle -> unexpected_ack_o=1 until reset.
REQ-037 Assert rst_i low with 3 in flight -> all outputs at reset values asynchronously; post-reset read completes normally.
